// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner
//   Pad-side input conditioner placed directly in front of the GPIO APB block.
//   Each raw pad bit goes through a synchroniser chain and then, optionally,
//   a per-bit debouncer. The block drives the conditioned levels onto GPIO_IN
//   and produces one-cycle RISE/FALL pulses per bit plus an OR'd CHANGE strobe.
//   Everything runs in the PCLK domain.
//
// Build option
//   GPIO_COND_DEBOUNCE_EN : when defined, a new level is accepted only after
//                           DEBOUNCE_CYCLES consecutive differing samples.
//                           When undefined, no counters are built and GPIO_IN
//                           follows the synchronised pad one cycle later.
//
// Ports
//   PCLK     in   1       clock
//   PRESET   in   1       synchronous active-high reset
//   ENABLE   in   1       1 = conditioning runs, 0 = outputs frozen
//   PAD_IN   in   IO_NUM  raw asynchronous pad inputs
//   GPIO_IN  out  IO_NUM  conditioned levels
//   RISE     out  IO_NUM  one-cycle pulse, first cycle GPIO_IN[i] shows 1
//   FALL     out  IO_NUM  one-cycle pulse, first cycle GPIO_IN[i] shows 0
//   CHANGE   out  1       |(RISE|FALL), same cycle as the pulses

// One conditioned bit: synchroniser, optional debounce counter, level and
// edge-pulse registers. accept is the combinational "level updates at this
// edge" signal, exported so the top can register CHANGE in the same cycle.
module gpio_in_cond_lane #(
    parameter int SYNC_STAGES     = 2
`ifdef GPIO_COND_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall,
    output logic accept
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    // The chain shifts even while disabled so metastability keeps settling.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_COND_DEBOUNCE_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter clears whenever the sample agrees with the held level, so
    // any glitch shorter than DEBOUNCE_CYCLES restarts the count. It clears
    // on acceptance too, hence it never passes DEBOUNCE_CYCLES-1.
    always_comb begin
        cnt_d  = '0;
        accept = 1'b0;
        if (en && (sync != level)) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) accept = 1'b1;
            else                                      cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign accept = en && (sync != level);
`endif

    // Pulses are registered with the level so they line up with the first
    // cycle GPIO_IN shows its new value; en=0 blocks accept, which both
    // freezes the level and forces the pulses low.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= accept &  sync;
            fall <= accept & ~sync;
            if (accept) level <= sync;
        end
    end

endmodule

module gpio_in_conditioner #(
    parameter int IO_NUM          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              ENABLE,
    input  logic [IO_NUM-1:0] PAD_IN,
    output logic [IO_NUM-1:0] GPIO_IN,
    output logic [IO_NUM-1:0] RISE,
    output logic [IO_NUM-1:0] FALL,
    output logic              CHANGE
);

`ifdef GPIO_COND_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
`endif

    // Elaboration-time guard on the legal parameter ranges.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_param_err
        $error("gpio_in_conditioner: parameter out of range");
    end

    logic [IO_NUM-1:0] accept;

    for (genvar i = 0; i < IO_NUM; i++) begin : g_lane
        gpio_in_cond_lane #(
            .SYNC_STAGES     (SYNC_STAGES)
`ifdef GPIO_COND_DEBOUNCE_EN
            ,
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
`endif
        ) u_lane (
            .clk    (PCLK),
            .rst    (PRESET),
            .en     (ENABLE),
            .pad    (PAD_IN[i]),
            .level  (GPIO_IN[i]),
            .rise   (RISE[i]),
            .fall   (FALL[i]),
            .accept (accept[i])
        );
    end

    // Registered from the same accept terms as the per-bit pulses, so it is
    // a single cycle wide no matter how many bits change together.
    always_ff @(posedge PCLK) begin
        if (PRESET) CHANGE <= 1'b0;
        else        CHANGE <= |accept;
    end

endmodule

// File: tb/tb_gpio_in_conditioner.sv
module tb_gpio_in_conditioner;

`ifdef GPIO_COND_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
    localparam int DEB    = 16;
`else
    localparam bit DEB_ON = 1'b0;
    localparam int DEB    = 1;
`endif
    localparam int S   = 2;
    localparam int LAT = S + DEB;  // edges from pad change to GPIO_IN update

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       ENABLE;
    logic [3:0] PAD_IN;
    logic [3:0] GPIO_IN, RISE, FALL;
    logic       CHANGE;

    gpio_in_conditioner #(.IO_NUM(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(16)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .ENABLE  (ENABLE),
        .PAD_IN  (PAD_IN),
        .GPIO_IN (GPIO_IN),
        .RISE    (RISE),
        .FALL    (FALL),
        .CHANGE  (CHANGE)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [3:0] g;
        logic [3:0] r;
        logic [3:0] f;
    } ev_t;
    ev_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int at, input logic [3:0] g, input logic [3:0] r, input logic [3:0] f);
        ev_t e;
        e.at = at; e.g = g; e.r = r; e.f = f;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_gpio"},   GPIO_IN, 4'h0);
        chk({nm, "_rise"},   RISE,    4'h0);
        chk({nm, "_fall"},   FALL,    4'h0);
        chk({nm, "_change"}, CHANGE,  1'b0);
    endtask

    // Monitor: any pulse activity must match the next expected event.
    always @(negedge PCLK) begin
        if ((|RISE) || (|FALL) || CHANGE) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {RISE, FALL, 3'b0, CHANGE}, 12'h0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("ev_edge",   cyc,     e.at);
                chk("ev_gpio",   GPIO_IN, e.g);
                chk("ev_rise",   RISE,    e.r);
                chk("ev_fall",   FALL,    e.f);
                chk("ev_change", CHANGE,  1'b1);
            end
        end
    end

    initial begin
        int c;
        logic v;

        // Reset with pads high: everything stays clear.
        PRESET = 1'b1; ENABLE = 1'b1; PAD_IN = 4'hF;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk_idle("reset");
        end
        PRESET = 1'b0;
        push(cyc + LAT, 4'hF, 4'hF, 4'h0);
        tick(LAT + 3);
        chk("post_reset_level", GPIO_IN, 4'hF);

        PAD_IN = 4'h0;
        push(cyc + LAT, 4'h0, 4'h0, 4'hF);
        tick(LAT + 3);

        // Glitch on bit 0 lasting 10 cycles.
        c = cyc;
        PAD_IN = 4'h1;
        if (!DEB_ON) push(c + LAT, 4'h1, 4'h1, 4'h0);
        tick(10);
        PAD_IN = 4'h0;
        if (!DEB_ON) push(c + 10 + LAT, 4'h0, 4'h0, 4'h1);
        tick(20);
        chk("glitch_level", GPIO_IN, 4'h0);

        // Bounce on bit 1: five toggles three cycles apart, ends high.
        for (int k = 0; k < 5; k++) begin
            c = cyc;
            v = (k % 2 == 0);
            PAD_IN[1] = v;
            if (k == 4 || !DEB_ON)
                push(c + LAT, v ? 4'h2 : 4'h0, v ? 4'h2 : 4'h0, v ? 4'h0 : 4'h2);
            if (k < 4) tick(3);
        end
        tick(LAT + 3);
        chk("bounce_level", GPIO_IN, 4'h2);
        PAD_IN = 4'h0;
        push(cyc + LAT, 4'h0, 4'h0, 4'h2);
        tick(LAT + 3);

        // Several bits at once.
        PAD_IN = 4'h5;
        push(cyc + LAT, 4'h5, 4'h5, 4'h0);
        tick(LAT + 3);
        PAD_IN = 4'hA;
        push(cyc + LAT, 4'hA, 4'hA, 4'h5);
        tick(LAT + 3);
        PAD_IN = 4'h0;
        push(cyc + LAT, 4'h0, 4'h0, 4'hA);
        tick(LAT + 3);

        // Disabled: level holds, then re-enable restarts debounce.
        ENABLE = 1'b0;
        PAD_IN = 4'hF;
        tick(40);
        chk("disabled_hold", GPIO_IN, 4'h0);
        ENABLE = 1'b1;
        push(cyc + DEB, 4'hF, 4'hF, 4'h0);
        tick(DEB + 3);
        chk("reenable_level", GPIO_IN, 4'hF);

        // ENABLE drops on the very edge that would accept.
        PAD_IN = 4'h0;
        tick(LAT - 1);
        ENABLE = 1'b0;
        tick(5);
        chk("enable_wins", GPIO_IN, 4'hF);
        ENABLE = 1'b1;
        push(cyc + DEB, 4'h0, 4'h0, 4'hF);
        tick(DEB + 3);

        // Reset while bit 2 is pending.
        PAD_IN = 4'h8;
        push(cyc + LAT, 4'h8, 4'h8, 4'h0);
        tick(LAT + 3);
        PAD_IN = 4'hC;
        tick(DEB_ON ? 12 : 1);
        PRESET = 1'b1;
        tick(1);
        chk_idle("midreset");
        PRESET = 1'b0;
        push(cyc + LAT, 4'hC, 4'hC, 4'h0);
        tick(LAT + 3);
        chk("midreset_level", GPIO_IN, 4'hC);

        // Single-cycle pulse on bit 3.
        PAD_IN = 4'h4;
        push(cyc + LAT, 4'h4, 4'h0, 4'h8);
        tick(LAT + 3);
        c = cyc;
        PAD_IN = 4'hC;
        if (!DEB_ON) push(c + LAT, 4'hC, 4'h8, 4'h0);
        tick(1);
        PAD_IN = 4'h4;
        if (!DEB_ON) push(c + 1 + LAT, 4'h4, 4'h0, 4'h8);
        tick(LAT + 4);
        chk("pulse_level", GPIO_IN, 4'h4);

        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
